// File: rtl/jzjpcc_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : jzjpcc_fetch_unit                                                |
// | Brief    : Fetch stage (PC, imem address) plus IF/ID pipeline register.     |
// |            Optional perf counters: JZJPCC_FETCH_PERF_COUNTERS_EN            |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module jzjpcc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR    = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTRUCTION = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] instAddr_fetch,
  input  logic [31:0] instData_fetch,
  input  logic        stall_fetch,
  input  logic        flush_decode,
  input  logic        branchTaken_execute,
  input  logic [31:0] branchTarget_execute,
  output logic [31:0] instruction_decode,
  output logic [31:0] pc_decode,
  output logic        valid_decode,
  output logic        misalignedTarget_execute,
  output logic [31:0] stallCount,
  output logic [31:0] flushCount
);

  localparam logic [31:0] c_pc_step = 32'd4;

  logic [31:0] r_pc;
  logic [31:0] w_pc_next;

  // The imem reads pcNext, so its data always tracks r_pc one cycle later.
  always_comb begin
    if (reset)
      w_pc_next = RESET_VECTOR;
    else if (branchTaken_execute)
      w_pc_next = {branchTarget_execute[31:2], 2'b00};
    else if (stall_fetch)
      w_pc_next = r_pc;
    else
      w_pc_next = r_pc + c_pc_step;
  end

  assign instAddr_fetch           = w_pc_next;
  assign misalignedTarget_execute = branchTaken_execute && (branchTarget_execute[1:0] != 2'b00);

  always_ff @(posedge clock) begin
    if (reset)
      r_pc <= RESET_VECTOR;
    else
      r_pc <= w_pc_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      instruction_decode <= NOP_INSTRUCTION;
      pc_decode          <= 32'h0;
      valid_decode       <= 1'b0;
    end else if (flush_decode) begin
      instruction_decode <= NOP_INSTRUCTION;
      pc_decode          <= r_pc;
      valid_decode       <= 1'b0;
    end else if (!stall_fetch) begin
      instruction_decode <= instData_fetch;
      pc_decode          <= r_pc;
      valid_decode       <= 1'b1;
    end
  end

`ifdef JZJPCC_FETCH_PERF_COUNTERS_EN
  logic [31:0] r_stall_count;
  logic [31:0] r_flush_count;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall_count <= 32'h0;
      r_flush_count <= 32'h0;
    end else begin
      if (stall_fetch && (r_stall_count != 32'hFFFF_FFFF))
        r_stall_count <= r_stall_count + 32'd1;
      if (flush_decode && (r_flush_count != 32'hFFFF_FFFF))
        r_flush_count <= r_flush_count + 32'd1;
    end
  end

  assign stallCount = r_stall_count;
  assign flushCount = r_flush_count;
`else
  assign stallCount = 32'h0;
  assign flushCount = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_jzjpcc_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_jzjpcc_fetch_unit                                             |
// | Brief    : Scoreboard bench for jzjpcc_fetch_unit with imem model.          |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_jzjpcc_fetch_unit;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instAddr_fetch;
  logic [31:0] instData_fetch = 32'h0;
  logic        stall_fetch, flush_decode, branchTaken_execute;
  logic [31:0] branchTarget_execute;
  logic [31:0] instruction_decode, pc_decode, stallCount, flushCount;
  logic        valid_decode, misalignedTarget_execute;

  jzjpcc_fetch_unit #(.RESET_VECTOR(RV), .NOP_INSTRUCTION(NOP)) dut (
    .clock(clock), .reset(reset),
    .instAddr_fetch(instAddr_fetch), .instData_fetch(instData_fetch),
    .stall_fetch(stall_fetch), .flush_decode(flush_decode),
    .branchTaken_execute(branchTaken_execute), .branchTarget_execute(branchTarget_execute),
    .instruction_decode(instruction_decode), .pc_decode(pc_decode), .valid_decode(valid_decode),
    .misalignedTarget_execute(misalignedTarget_execute),
    .stallCount(stallCount), .flushCount(flushCount)
  );

  always #5 clock = ~clock;

  // Instruction memory contents are a fixed hash of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Synchronous-read imem.
  always @(posedge clock) instData_fetch <= mem_word(instAddr_fetch);

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pcd;
    logic        valid;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t q[$];
  int n_pass = 0;
  int n_total = 0;

  // Reference state: where the fetch stage is, and what decode should see.
  logic [31:0] m_pc = RV;
  logic [31:0] m_inst = NOP, m_pcd = 32'h0, m_sc = 32'h0, m_fc = 32'h0;
  logic        m_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, want);
  endtask

  // Drive one cycle of inputs, check combinational outputs, push post-edge expectation.
  task automatic step(input logic rst, input logic stl, input logic fl,
                      input logic br, input logic [31:0] tgt);
    logic [31:0] next_addr;
    @(negedge clock);
    reset = rst; stall_fetch = stl; flush_decode = fl;
    branchTaken_execute = br; branchTarget_execute = tgt;
    // Fetch address: reset vector, word-aligned redirect, same word on stall, else next word.
    if (rst)      next_addr = RV;
    else if (br)  next_addr = tgt & ~32'h3;
    else if (stl) next_addr = m_pc;
    else          next_addr = m_pc + 32'd4;
    #1;
    check("instAddr", instAddr_fetch, next_addr);
    check("misaligned", {31'h0, misalignedTarget_execute}, {31'h0, br && (tgt % 4 != 0)});
    if (rst) begin
      m_inst = NOP; m_pcd = 32'h0; m_valid = 1'b0; m_sc = 32'h0; m_fc = 32'h0;
    end else begin
      if (fl) begin
        m_inst = NOP; m_pcd = m_pc; m_valid = 1'b0;
      end else if (!stl) begin
        m_inst = mem_word(m_pc); m_pcd = m_pc; m_valid = 1'b1;
      end
`ifdef JZJPCC_FETCH_PERF_COUNTERS_EN
      if (stl && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
      if (fl && m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
`endif
    end
    m_pc = next_addr;
    q.push_back('{inst: m_inst, pcd: m_pcd, valid: m_valid, sc: m_sc, fc: m_fc});
  endtask

  // Monitor: every edge the IF/ID register presents a new value.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("instruction_decode", instruction_decode, e.inst);
        check("pc_decode", pc_decode, e.pcd);
        check("valid_decode", {31'h0, valid_decode}, {31'h0, e.valid});
        check("stallCount", stallCount, e.sc);
        check("flushCount", flushCount, e.fc);
      end
    end
  end

  initial begin
    reset = 1'b1; stall_fetch = 1'b0; flush_decode = 1'b0;
    branchTaken_execute = 1'b0; branchTarget_execute = 32'h0;
    // Reset, then sequential fetch up to pc 0x10
    step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0);
    // Stall three cycles, then resume
    repeat (3) step(0, 1, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0);
    // Redirect with flush
    step(0, 0, 1, 1, 32'h100);
    repeat (2) step(0, 0, 0, 0, 0);
    // Stall + redirect + flush together
    step(0, 1, 1, 1, 32'h40);
    repeat (2) step(0, 0, 0, 0, 0);
    // Misaligned target and PC wrap
    step(0, 0, 1, 1, 32'h42);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 32'hFFFF_FFFC);
    repeat (3) step(0, 0, 0, 0, 0);
    // Flush with stall, no redirect: PC held, bubble loaded
    step(0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    // Counters, then reset during stall
    step(1, 0, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 1, 0, 1, 32'h200);
    repeat (2) step(0, 0, 0, 0, 0);
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 30),
           ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 12),
           ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | $urandom_range(0, 15) : $urandom);
    end
    step(0, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #2;
    n_total++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
